// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-time generator array.
// Latency: n/a (types and a pure compare helper only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} pwm_dir_t;

  // Duty compare: the down slope uses <= so the high time is exactly 2*duty
  // steps in center mode and the pulse never touches the count=0 point twice.
  function automatic logic duty_hit(input pwm_mode_t m, input pwm_dir_t d,
                                    input int unsigned cnt, input int unsigned duty);
    if (m == PWM_CENTER && d == DIR_DN) return cnt <= duty;
    return cnt < duty;
  endfunction

endpackage

// File: rtl/pwm_dtg_array_if.sv
// Duty-value stream into the PWM array (all channels per beat).
// Latency: n/a (wiring only).
// Backpressure: consumer holds str_rdy low while it cannot accept a beat.
interface pwm_dtg_array_if #(
  parameter int DWC = 8,
  parameter int CHN = 4
);
  logic [CHN-1:0][DWC-1:0] str_dat;
  logic                    str_vld;
  logic                    str_rdy;

  modport master (output str_dat, output str_vld, input str_rdy);
  modport slave  (input str_dat, input str_vld, output str_rdy);
endinterface

// File: rtl/pwm_deadtime.sv
// One complementary output pair with programmable dead time inserted on every raw edge.
// Latency: raw -> pins 1 cycle, plus dtm cycles with both pins low after each raw edge.
// Backpressure: none; follows raw every cycle.
module pwm_deadtime #(
  parameter int DTW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           raw,
  input  logic [DTW-1:0] dtm,
  output logic           pwm_p,
  output logic           pwm_n
);

  logic           raw_q;
  logic [DTW-1:0] dcnt;

  // Edge detect, dead-time countdown and pin drive; an edge always restarts the gap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      raw_q <= 1'b0;
      dcnt  <= '0;
      pwm_p <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      raw_q <= raw;
      if (raw != raw_q) begin
        dcnt  <= dtm;
        pwm_p <= (dtm == '0) & raw;
        pwm_n <= (dtm == '0) & ~raw;
      end else if (dcnt != '0) begin
        dcnt  <= dcnt - 1'b1;
        pwm_p <= (dcnt == DTW'(1)) & raw;
        pwm_n <= (dcnt == DTW'(1)) & ~raw;
      end else begin
        pwm_p <= raw;
        pwm_n <= ~raw;
      end
    end
  end

endmodule

// File: rtl/pwm_dtg_array.sv
// Multi-channel PWM: shared edge/center-aligned counter, double-buffered duties, dead-time outputs.
// Latency: counter -> raw compare 1 cycle, raw -> pins 1 cycle plus dtm cycles on each raw edge.
// Backpressure: str_rdy low while the shadow holds an unconsumed duty set; reopens after the next period start.
module pwm_dtg_array
  import pwm_pkg::*;
#(
  parameter int DWC = 8,
  parameter int CHN = 4,
  parameter int DTW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cke,
  input  logic                ena,
  input  logic                mode,
  input  logic [DWC-1:0]      rng,
  input  logic [DTW-1:0]      dtm,
  pwm_dtg_array_if.slave      str,
  output logic                prd,
  output logic [CHN-1:0]      pwm_p,
  output logic [CHN-1:0]      pwm_n
);

  logic [DWC-1:0]          cnt;
  logic [DWC:0]            cnt_inc;
  pwm_dir_t                dir;
  pwm_mode_t               mode_q;
  logic [CHN-1:0][DWC-1:0] shd;
  logic [CHN-1:0][DWC-1:0] act;
  logic [CHN-1:0][DWC-1:0] act_nxt;
  logic                    full;
  logic                    xfer;
  logic [CHN-1:0]          raw;
  logic                    clr;

  // Extra bit so the wrap test cannot overflow when cnt is at its maximum.
  assign cnt_inc     = {1'b0, cnt} + (DWC+1)'(1);
  assign prd         = ena & cke & (cnt == '0);
  assign xfer        = str.str_vld & ~full;
  assign str.str_rdy = ~full;
  assign clr         = ~ena;
  // The duty being loaded this cycle already drives the compare, so a new
  // period starts with its new duty rather than one step late.
  assign act_nxt     = (prd && full) ? shd : act;

  // Period counter and slope direction; mode is only sampled while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dir    <= DIR_UP;
      mode_q <= PWM_EDGE;
    end else if (!ena) begin
      cnt    <= '0;
      dir    <= DIR_UP;
      mode_q <= pwm_mode_t'(mode);
    end else if (cke) begin
      if (mode_q == PWM_EDGE) begin
        dir <= DIR_UP;
        if (cnt_inc >= {1'b0, rng}) cnt <= '0;
        else                        cnt <= cnt_inc[DWC-1:0];
      end else if (rng == '0) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (dir == DIR_UP) begin
        cnt <= cnt_inc[DWC-1:0];
        if (cnt_inc >= {1'b0, rng}) dir <= DIR_DN;
      end else begin
        if (cnt == '0 || cnt == DWC'(1)) begin
          cnt <= '0;
          dir <= DIR_UP;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Shadow accepts a beat when empty; the period start moves it into the active set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      shd  <= '0;
      act  <= '0;
    end else if (prd && full) begin
      act  <= shd;
      full <= 1'b0;
    end else if (xfer) begin
      shd  <= str.str_dat;
      full <= 1'b1;
    end
  end

  // Registered per-channel compare against the next-active duty.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      raw <= '0;
    end else begin
      for (int i = 0; i < CHN; i++) begin
        raw[i] <= duty_hit(mode_q, dir, 32'(cnt), 32'(act_nxt[i]));
      end
    end
  end

  for (genvar g = 0; g < CHN; g++) begin : g_dt
    pwm_deadtime #(.DTW(DTW)) u_dt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .raw   (raw[g]),
      .dtm   (dtm),
      .pwm_p (pwm_p[g]),
      .pwm_n (pwm_n[g])
    );
  end

endmodule
